err_inj_scheduler: RTL and testbench
====================================

Name: err_inj_scheduler

Overview:
Synthesizable error-injection campaign controller for the SPI-over-coax link. It holds a small table of injection phases and steps through them frame by frame. For each frame request from the framer it produces corruption masks (data/CRC/SYNC XOR masks, clock-glitch strobe), which the framer applies to the outgoing frame. It also keeps per-campaign error and frame statistics.

Parameters:
NUM_PHASES, 4, phase table depth (power of 2, ≥2)
LFSR_SEED, 32'hDEADBEEF, LFSR reset value (must be nonzero)
CNT_W, 16, width of frame/error counters and cfg_frames

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cfg_we  in  1  write phase entry (ignored while busy)
cfg_addr  in  $clog2(NUM_PHASES)  phase index
cfg_type  in  3  error type (ERR_* codes 0..6)
cfg_rate  in  16  injection threshold, 1/65536 units; 16'hFFFF = always
cfg_burst  in  8  burst length in frames
cfg_frames  in  CNT_W  phase length in frames; 0 = campaign terminator
start  in  1  begin campaign at phase 0 (pulse)
abort  in  1  stop campaign (pulse)
loop_en  in  1  wrap to phase 0 after the last phase instead of finishing
frame_req  in  1  one-cycle pulse per outgoing frame
mask_valid  out  1  masks valid (1 cycle)
data_mask  out  32  XOR mask for 32-bit payload
crc_mask  out  8  XOR mask for CRC byte
sync_mask  out  8  XOR mask for SYNC byte
glitch  out  1  clock-glitch request for this frame
busy  out  1  campaign running
done  out  1  one-cycle pulse at normal completion
cur_phase  out  $clog2(NUM_PHASES)  active phase index
err_count  out  CNT_W  frames injected this campaign, saturating
frame_count  out  CNT_W  frames seen this campaign, saturating

Behaviour:
- Reset is asynchronous: all outputs 0, table entries 0, LFSR = LFSR_SEED, FSM = IDLE.
- LFSR: 32-bit, free-running every clock; next = {l[30:0], l[31]^l[21]^l[1]^l[0]}.
- Inject decision, sampled at frame_req: rate==16'hFFFF, or l[15:0] < rate. rate==0 or type NONE never injects.
- FSM states:
  - IDLE: start → LOAD (clears err_count and frame_count, cur_phase=0).
  - LOAD: read entry. If frames==0 → FINISH; otherwise clear phase frame counter and burst counter, then RUN.
  - RUN: each frame_req increments the phase counter. On the frame where the count reaches cfg_frames → NEXT. That frame belongs to the ending phase.
  - NEXT: if cur_phase==NUM_PHASES-1 or the next entry's frames==0, go to loop (cur_phase=0, LOAD) when loop_en=1, else FINISH. Otherwise cur_phase+1, LOAD.
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in LOAD/RUN/NEXT.
- Mask latency: frame_req in cycle t gives mask_valid=1 in cycle t+1. This holds in every state, including IDLE. Outside RUN, and on frames with no injection, all masks and glitch are 0. frame_req in LOAD/NEXT is passed clean and is not counted.
- Mask content on an injecting frame (l = LFSR at frame_req):
  - BIT_FLIP: data_mask = 1<<l[4:0].
  - FRAME_CORRUPT: data_mask = l | 32'h1.
  - CRC_MISMATCH: crc_mask = l[7:0] | 8'h01.
  - SYNC_LOST: sync_mask = 8'hFF.
  - CLOCK_GLITCH: glitch = 1.
  - BURST_ERROR: the decision is evaluated only when the burst counter is 0. On a hit, the burst counter is loaded with cfg_burst. Each frame with burst counter > 0 gets data_mask = 1<<l[4:0], and the counter decrements. cfg_burst==0 is treated as 1.
- Bursts are truncated at a phase boundary.
- err_count increments on frames with any nonzero mask or glitch. Counters saturate at all-ones.
- Simultaneous events:
  - abort wins over start and frame_req; in any busy state it goes to IDLE next cycle with no done pulse and the burst counter cleared. The mask for a frame_req in the same cycle is clean.
  - start while busy is ignored.
  - cfg_we while busy is ignored.
  - cfg_we and start in the same cycle in IDLE: the write lands first, and the campaign uses the new entry.
- Reset mid-campaign: immediate return to reset values; the table is cleared.

Decomposition:
- Package err_inj_pkg: ERR_NONE..ERR_BURST_ERROR (3-bit codes 0..6, matching the bench injector), FSM state encoding, phase-entry struct {type, rate, burst, frames}.
- Sub-module err_lfsr32: free-running LFSR with seed parameter and async reset.

Test Plan:
- Idle pass-through: 3 frame_req with no start → 3 mask_valid pulses at t+1 with all masks 0; busy=0, err_count=0.
- Single CRC phase: phase0 {CRC, FFFF, -, 3}, phase1 frames=0; start, 3 frame_req → each crc_mask has bit0=1, data/sync=0; err_count=3, frame_count=3; done pulses once; busy falls.
- Burst truncation: phase0 {BURST, FFFF, 5, 3}, phase1 {NONE, 0, -, 4}, phase2 terminator → 3 one-hot data_masks, then 4 zero masks; err_count=3, frame_count=7.
- Loop and abort: phase0 {SYNC_LOST, FFFF, -, 2}, phase1 {CLOCK_GLITCH, FFFF, -, 2}, loop_en=1 → sync_mask=FF ×2, glitch ×2, cur_phase returns to 0. Abort after the 5th frame → busy=0 next cycle, no done.
- Lockout: cfg_we to phase0 and start during RUN → table unchanged after abort (verified by rerun), campaign not restarted.
- Async reset asserted mid-RUN, between clock edges → outputs 0 without waiting for a clk edge; a subsequent start with an empty table → done pulse with no RUN.

Source files
------------

// File: rtl/err_inj_pkg.sv
// Shared types for the SPI-over-coax error-injection scheduler: error codes,
// FSM encoding and the phase-table entry layout.
package err_inj_pkg;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_BIT_FLIP      = 3'd1,
        ERR_FRAME_CORRUPT = 3'd2,
        ERR_CRC_MISMATCH  = 3'd3,
        ERR_SYNC_LOST     = 3'd4,
        ERR_CLOCK_GLITCH  = 3'd5,
        ERR_BURST_ERROR   = 3'd6
    } err_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Frame lengths are stored zero-extended so the entry layout does not
    // depend on the counter width chosen by the instantiating module.
    localparam int FRAMES_W = 32;

    typedef struct packed {
        err_type_e           etype;
        logic [15:0]         rate;
        logic [7:0]          burst;
        logic [FRAMES_W-1:0] frames;
    } phase_entry_t;

    function automatic logic rate_hit(input logic [15:0] rate, input logic [15:0] rnd);
        return (rate == 16'hFFFF) || (rnd < rate);
    endfunction

endpackage

// File: rtl/err_lfsr32.sv
// Free-running 32-bit Fibonacci LFSR (taps 31,21,1,0) used as the
// injection random source.
module err_lfsr32 #(
    parameter logic [31:0] SEED = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] lfsr
);

    logic [31:0] lfsr_r;

    // Shift register advances every clock regardless of campaign state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= {lfsr_r[30:0], lfsr_r[31] ^ lfsr_r[21] ^ lfsr_r[1] ^ lfsr_r[0]};
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/err_inj_scheduler.sv
// Error-injection campaign controller: steps through a phase table and
// answers every frame request with registered corruption masks one cycle later.
module err_inj_scheduler
    import err_inj_pkg::*;
#(
    parameter int          NUM_PHASES = 4,
    parameter logic [31:0] LFSR_SEED  = 32'hDEADBEEF,
    parameter int          CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_PHASES)-1:0] cfg_addr,
    input  logic [2:0]                    cfg_type,
    input  logic [15:0]                   cfg_rate,
    input  logic [7:0]                    cfg_burst,
    input  logic [CNT_W-1:0]              cfg_frames,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          loop_en,
    input  logic                          frame_req,
    output logic                          mask_valid,
    output logic [31:0]                   data_mask,
    output logic [7:0]                    crc_mask,
    output logic [7:0]                    sync_mask,
    output logic                          glitch,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NUM_PHASES)-1:0] cur_phase,
    output logic [CNT_W-1:0]              err_count,
    output logic [CNT_W-1:0]              frame_count
);

    localparam int                 PW         = $clog2(NUM_PHASES);
    localparam logic [PW-1:0]      LAST_PHASE = PW'(NUM_PHASES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONES   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam phase_entry_t       ENTRY_ZERO = {$bits(phase_entry_t){1'b0}};

    state_e           state_r, state_s;
    phase_entry_t     table_r [NUM_PHASES];
    phase_entry_t     cur_entry_s, next_entry_s;
    logic [31:0]      lfsr_s, one_hot_s;
    logic [PW-1:0]    cur_phase_r, nxt_phase_s;
    logic [CNT_W-1:0] phase_cnt_r, phase_cnt_inc_s, err_count_r, frame_count_r;
    logic [7:0]       burst_cnt_r, burst_cnt_s, burst_last_s;
    logic             run_frame_s, hit_s, phase_end_s, last_s, inject_s, cfg_open_s;
    logic [31:0]      data_s;
    logic [7:0]       crc_s, sync_s;
    logic             glitch_s, busy_s, done_s;
    logic             mask_valid_r, glitch_r, busy_r, done_r;
    logic [31:0]      data_mask_r;
    logic [7:0]       crc_mask_r, sync_mask_r;

    err_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr_s)
    );

    assign cur_entry_s     = table_r[cur_phase_r];
    assign nxt_phase_s     = cur_phase_r + 1'b1;
    assign next_entry_s    = table_r[nxt_phase_s];
    assign phase_cnt_inc_s = phase_cnt_r + 1'b1;
    assign phase_end_s     = (FRAMES_W'(phase_cnt_inc_s) == cur_entry_s.frames);
    assign last_s          = (cur_phase_r == LAST_PHASE) ||
                             (next_entry_s.frames == {FRAMES_W{1'b0}});
    assign run_frame_s     = (state_r == ST_RUN) && frame_req && !abort;
    assign hit_s           = (cur_entry_s.etype != ERR_NONE) && (cur_entry_s.rate != 16'h0000) &&
                             rate_hit(cur_entry_s.rate, lfsr_s[15:0]);
    assign one_hot_s       = 32'h0000_0001 << lfsr_s[4:0];
    assign burst_last_s    = (cur_entry_s.burst == 8'd0) ? 8'd0 : cur_entry_s.burst - 8'd1;
    assign inject_s        = (data_s != 32'h0) || (crc_s != 8'h00) || (sync_s != 8'h00) || glitch_s;
    assign cfg_open_s      = (state_r == ST_IDLE) || (state_r == ST_FINISH);

    // Campaign state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort overrides every other event in busy states.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) state_s = ST_LOAD;
                else                 state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort)                                          state_s = ST_IDLE;
                else if (cur_entry_s.frames == {FRAMES_W{1'b0}})    state_s = ST_FINISH;
                else                                                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                           state_s = ST_IDLE;
                else if (frame_req && phase_end_s)   state_s = ST_NEXT;
                else                                 state_s = ST_RUN;
            end
            ST_NEXT: begin
                if (abort)                 state_s = ST_IDLE;
                else if (last_s && !loop_en) state_s = ST_FINISH;
                else                       state_s = ST_LOAD;
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Mask generation for the current frame plus next busy/done values.
    always_comb begin
        data_s      = 32'h0;
        crc_s       = 8'h00;
        sync_s      = 8'h00;
        glitch_s    = 1'b0;
        burst_cnt_s = burst_cnt_r;
        busy_s      = (state_s == ST_LOAD) || (state_s == ST_RUN) || (state_s == ST_NEXT);
        done_s      = (state_s == ST_FINISH);
        if (run_frame_s) begin
            case (cur_entry_s.etype)
                ERR_BIT_FLIP:      data_s   = hit_s ? one_hot_s : 32'h0;
                ERR_FRAME_CORRUPT: data_s   = hit_s ? (lfsr_s | 32'h0000_0001) : 32'h0;
                ERR_CRC_MISMATCH:  crc_s    = hit_s ? (lfsr_s[7:0] | 8'h01) : 8'h00;
                ERR_SYNC_LOST:     sync_s   = hit_s ? 8'hFF : 8'h00;
                ERR_CLOCK_GLITCH:  glitch_s = hit_s;
                ERR_BURST_ERROR: begin
                    // The triggering frame is the first of the burst.
                    if (burst_cnt_r != 8'd0) begin
                        data_s      = one_hot_s;
                        burst_cnt_s = burst_cnt_r - 8'd1;
                    end else if (hit_s) begin
                        data_s      = one_hot_s;
                        burst_cnt_s = burst_last_s;
                    end else begin
                        data_s      = 32'h0;
                        burst_cnt_s = burst_cnt_r;
                    end
                end
                default: begin
                    data_s   = 32'h0;
                    glitch_s = 1'b0;
                end
            endcase
        end else begin
            burst_cnt_s = burst_cnt_r;
        end
    end

    // Phase table; writable only while no campaign is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                table_r[i] <= ENTRY_ZERO;
            end
        end else if (cfg_we && cfg_open_s) begin
            table_r[cfg_addr] <= '{etype:  err_type_e'(cfg_type),
                                   rate:   cfg_rate,
                                   burst:  cfg_burst,
                                   frames: FRAMES_W'(cfg_frames)};
        end
    end

    // Phase sequencing, burst tracking and saturating statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_phase_r   <= {PW{1'b0}};
            phase_cnt_r   <= CNT_ZERO;
            burst_cnt_r   <= 8'd0;
            err_count_r   <= CNT_ZERO;
            frame_count_r <= CNT_ZERO;
        end else begin
            if (abort || (state_r == ST_LOAD)) begin
                burst_cnt_r <= 8'd0;
            end else begin
                burst_cnt_r <= burst_cnt_s;
            end
            if ((state_r == ST_IDLE) && start && !abort) begin
                cur_phase_r   <= {PW{1'b0}};
                err_count_r   <= CNT_ZERO;
                frame_count_r <= CNT_ZERO;
            end else if (run_frame_s) begin
                phase_cnt_r <= phase_cnt_inc_s;
                if (frame_count_r != CNT_ONES) frame_count_r <= frame_count_r + 1'b1;
                if (inject_s && (err_count_r != CNT_ONES)) err_count_r <= err_count_r + 1'b1;
            end else if (state_r == ST_LOAD) begin
                phase_cnt_r <= CNT_ZERO;
            end else if ((state_r == ST_NEXT) && !abort) begin
                if (!last_s)      cur_phase_r <= nxt_phase_s;
                else if (loop_en) cur_phase_r <= {PW{1'b0}};
            end
        end
    end

    // Output registers: every frame request is answered exactly one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_valid_r <= 1'b0;
            data_mask_r  <= 32'h0;
            crc_mask_r   <= 8'h00;
            sync_mask_r  <= 8'h00;
            glitch_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            mask_valid_r <= frame_req;
            data_mask_r  <= data_s;
            crc_mask_r   <= crc_s;
            sync_mask_r  <= sync_s;
            glitch_r     <= glitch_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign mask_valid  = mask_valid_r;
    assign data_mask   = data_mask_r;
    assign crc_mask    = crc_mask_r;
    assign sync_mask   = sync_mask_r;
    assign glitch      = glitch_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign cur_phase   = cur_phase_r;
    assign err_count   = err_count_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_err_inj_scheduler.sv
// Self-checking bench for err_inj_scheduler: per-frame vector table with a
// mask scoreboard driven by an independent LFSR model, plus corner sequences.
module tb_err_inj_scheduler;

    localparam logic [2:0] T_NONE   = 3'd0;
    localparam logic [2:0] T_BIT    = 3'd1;
    localparam logic [2:0] T_FRAME  = 3'd2;
    localparam logic [2:0] T_CRC    = 3'd3;
    localparam logic [2:0] T_SYNC   = 3'd4;
    localparam logic [2:0] T_GLITCH = 3'd5;
    localparam logic [2:0] T_BURST  = 3'd6;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  crc;
        logic [7:0]  sync;
        logic        glitch;
    } mask_t;

    typedef struct {
        logic [2:0] inj;
        logic [1:0] phase;
        logic       busy;
    } vec_t;

    logic        clk, rst;
    logic        cfg_we, start, abort, loop_en, frame_req;
    logic [1:0]  cfg_addr;
    logic [2:0]  cfg_type;
    logic [15:0] cfg_rate;
    logic [7:0]  cfg_burst;
    logic [15:0] cfg_frames;
    logic        mask_valid, glitch, busy, done;
    logic [31:0] data_mask;
    logic [7:0]  crc_mask, sync_mask;
    logic [1:0]  cur_phase;
    logic [15:0] err_count, frame_count;

    logic [31:0] lfsr_m;
    mask_t       sb_q[$];
    mask_t       mon_m;
    vec_t        vecs[$];
    int          tests, fails, done_cnt, busy_cyc, d0, b0;

    err_inj_scheduler dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_type(cfg_type),
        .cfg_rate(cfg_rate), .cfg_burst(cfg_burst), .cfg_frames(cfg_frames),
        .start(start), .abort(abort), .loop_en(loop_en), .frame_req(frame_req),
        .mask_valid(mask_valid), .data_mask(data_mask), .crc_mask(crc_mask),
        .sync_mask(sync_mask), .glitch(glitch), .busy(busy), .done(done),
        .cur_phase(cur_phase), .err_count(err_count), .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 32'hDEADBEEF;
        else     lfsr_m <= {lfsr_m[30:0], lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0]};
    end

    function automatic mask_t exp_mask(input logic [2:0] t, input logic [31:0] l);
        mask_t m;
        m = '0;
        case (t)
            T_BIT, T_BURST: m.data = 32'h1 << l[4:0];
            T_FRAME:        m.data = l | 32'h1;
            T_CRC:          m.crc  = l[7:0] | 8'h01;
            T_SYNC:         m.sync = 8'hFF;
            T_GLITCH:       m.glitch = 1'b1;
            default:        m = '0;
        endcase
        return m;
    endfunction

    // Scoreboard consumer and event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            if (mask_valid) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL mask_unexpected: got mask_valid=1, required no pending frame");
                end else begin
                    mon_m = sb_q.pop_front();
                    if ({data_mask, crc_mask, sync_mask, glitch} !== mon_m) begin
                        fails++;
                        $display("FAIL mask: got data=%h crc=%h sync=%h glitch=%b, required data=%h crc=%h sync=%h glitch=%b",
                                 data_mask, crc_mask, sync_mask, glitch,
                                 mon_m.data, mon_m.crc, mon_m.sync, mon_m.glitch);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [2:0] t, input logic [15:0] r,
                               input logic [7:0] b, input logic [15:0] f);
        cfg_we = 1'b1; cfg_addr = a; cfg_type = t; cfg_rate = r; cfg_burst = b; cfg_frames = f;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_campaign();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [2:0] t);
        frame_req = 1'b1;
        sb_q.push_back(exp_mask(t, lfsr_m));
        tick();
        frame_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_frame(vecs[i].inj);
            check($sformatf("cur_phase[%0d]", i), 64'(cur_phase), 64'(vecs[i].phase));
            check($sformatf("busy[%0d]", i), 64'(busy), 64'(vecs[i].busy));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0; fails = 0; done_cnt = 0; busy_cyc = 0;
        rst = 1'b1; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; frame_req = 1'b0;
        cfg_addr = 2'd0; cfg_type = 3'd0; cfg_rate = 16'h0; cfg_burst = 8'd0; cfg_frames = 16'd0;

        // idle 0-2, CRC 3-5, burst 6-12, loop 13-17, rerun 18-21
        for (int i = 0; i < 3; i++) vecs.push_back('{T_NONE, 2'd0, 1'b0});
        vecs.push_back('{T_CRC, 2'd0, 1'b1});
        vecs.push_back('{T_CRC, 2'd0, 1'b1});
        vecs.push_back('{T_CRC, 2'd0, 1'b0});
        vecs.push_back('{T_BURST, 2'd0, 1'b1});
        vecs.push_back('{T_BURST, 2'd0, 1'b1});
        vecs.push_back('{T_BURST, 2'd1, 1'b1});
        for (int i = 0; i < 3; i++) vecs.push_back('{T_NONE, 2'd1, 1'b1});
        vecs.push_back('{T_NONE, 2'd1, 1'b0});
        vecs.push_back('{T_SYNC, 2'd0, 1'b1});
        vecs.push_back('{T_SYNC, 2'd1, 1'b1});
        vecs.push_back('{T_GLITCH, 2'd1, 1'b1});
        vecs.push_back('{T_GLITCH, 2'd0, 1'b1});
        vecs.push_back('{T_SYNC, 2'd0, 1'b1});
        vecs.push_back('{T_SYNC, 2'd0, 1'b1});
        vecs.push_back('{T_SYNC, 2'd1, 1'b1});
        vecs.push_back('{T_GLITCH, 2'd1, 1'b1});
        vecs.push_back('{T_GLITCH, 2'd1, 1'b0});

        tick();
        check("rst_mask_valid", 64'(mask_valid), 64'd0);
        check("rst_masks", 64'({data_mask, crc_mask, sync_mask, glitch}), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_counts", 64'({cur_phase, err_count, frame_count}), 64'd0);
        #12 rst = 1'b0;
        tick();

        apply_vecs(0, 2);
        check("idle_err_count", 64'(err_count), 64'd0);

        // Write lands in the same cycle the campaign is started.
        write_entry(2'd1, T_NONE, 16'h0, 8'd0, 16'd0);
        d0 = done_cnt;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_type = T_CRC; cfg_rate = 16'hFFFF; cfg_burst = 8'd0; cfg_frames = 16'd3;
        start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        tick();
        apply_vecs(3, 5);
        check("crc_err_count", 64'(err_count), 64'd3);
        check("crc_frame_count", 64'(frame_count), 64'd3);
        check("crc_done_pulses", 64'(done_cnt - d0), 64'd1);

        write_entry(2'd0, T_BURST, 16'hFFFF, 8'd5, 16'd3);
        write_entry(2'd1, T_NONE, 16'h0, 8'd0, 16'd4);
        write_entry(2'd2, T_NONE, 16'h0, 8'd0, 16'd0);
        d0 = done_cnt;
        start_campaign();
        apply_vecs(6, 12);
        check("burst_err_count", 64'(err_count), 64'd3);
        check("burst_frame_count", 64'(frame_count), 64'd7);
        check("burst_done_pulses", 64'(done_cnt - d0), 64'd1);

        write_entry(2'd0, T_SYNC, 16'hFFFF, 8'd0, 16'd2);
        write_entry(2'd1, T_GLITCH, 16'hFFFF, 8'd0, 16'd2);
        loop_en = 1'b1;
        start_campaign();
        apply_vecs(13, 17);
        d0 = done_cnt;
        abort = 1'b1; frame_req = 1'b1;
        sb_q.push_back(exp_mask(T_NONE, lfsr_m));
        tick();
        abort = 1'b0; frame_req = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        loop_en = 1'b0;

        // Table write and restart attempt while running must be ignored.
        start_campaign();
        send_frame(T_SYNC);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_type = T_CRC; cfg_rate = 16'hFFFF; cfg_burst = 8'd0; cfg_frames = 16'd9;
        start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        send_frame(T_SYNC);
        check("lock_frame_count", 64'(frame_count), 64'd2);
        check("lock_cur_phase", 64'(cur_phase), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("lock_abort_busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        start_campaign();
        apply_vecs(18, 21);
        check("rerun_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("rerun_err_count", 64'(err_count), 64'd4);

        // Asynchronous reset between clock edges while a mask is being presented.
        start_campaign();
        frame_req = 1'b1;
        sb_q.push_back(exp_mask(T_SYNC, lfsr_m));
        tick();
        frame_req = 1'b0;
        @(negedge clk);
        #2;
        check("pre_rst_err_count", 64'(err_count), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_mask", 64'({mask_valid, sync_mask}), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_counts", 64'({err_count, frame_count}), 64'd0);
        #10 rst = 1'b0;
        tick();
        d0 = done_cnt; b0 = busy_cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("empty_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("empty_busy_cycles", 64'(busy_cyc - b0), 64'd1);
        check("empty_frame_count", 64'(frame_count), 64'd0);

        repeat (2) tick();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
